// File: rtl/checkdigit_sched_if.sv
// Requester and engine signal bundle for the shared check-digit scheduler.
// slave = scheduler side, master = clients plus engine side.
interface checkdigit_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DIGITS = 15
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ*DIGITS*4-1:0] frame;
  logic [N_REQ-1:0]          ack;
  logic [N_REQ-1:0]          done;
  logic [3:0]                result;
  logic                      err;
  logic                      busy;
  logic [3:0]                eng_in_num;
  logic                      eng_in_valid;
  logic                      eng_out_valid;
  logic [3:0]                eng_out;

  modport slave (
    input  req, frame, eng_out_valid, eng_out,
    output ack, done, result, err, busy, eng_in_num, eng_in_valid
  );

  modport master (
    output req, frame, eng_out_valid, eng_out,
    input  ack, done, result, err, busy, eng_in_num, eng_in_valid
  );
endinterface

// File: rtl/checkdigit_sched.sv
// Round-robin scheduler sharing one check-digit engine among N_REQ requesters:
// grants a requester, streams its frame as one gap-free burst, returns the result.
module checkdigit_sched #(
  parameter int N_REQ   = 4,
  parameter int DIGITS  = 15,
  parameter int TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  checkdigit_sched_if.slave  bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int FW    = DIGITS * 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [FW-5:0]     frame_q, frame_d;
  logic              eng_in_valid_q, eng_in_valid_d;
  logic [3:0]        eng_in_num_q, eng_in_num_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [3:0]        result_q, result_d;
  logic              err_q, err_d;

  logic              grant_valid_s;
  logic [PTR_W-1:0]  grant_idx_s;
  logic [PTR_W-1:0]  cand_s;
  logic [FW-1:0]     grant_frame_s;
  logic [N_REQ-1:0]  ack_s;

  // Round-robin search starting just above the last grant, wrapping modulo N_REQ.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s        = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
      grant_idx_s   = (!grant_valid_s && bus.req[cand_s]) ? cand_s : grant_idx_s;
      grant_valid_s = grant_valid_s | bus.req[cand_s];
    end
  end

  // Select the granted frame and form the combinational ack pulse.
  always_comb begin
    grant_frame_s = '0;
    ack_s         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_frame_s = (grant_idx_s == PTR_W'(i)) ? bus.frame[i*FW +: FW] : grant_frame_s;
      ack_s[i]      = (state_q == IDLE) && grant_valid_s && (grant_idx_s == PTR_W'(i));
    end
  end

  // Next-state and registered-output logic; rr_ptr doubles as the current owner.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    k_d            = k_q;
    wait_d         = wait_q;
    frame_d        = frame_q;
    eng_in_valid_d = 1'b0;
    eng_in_num_d   = 4'h0;
    done_d         = '0;
    result_d       = result_q;
    err_d          = err_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d        = SEND;
          rr_ptr_d       = grant_idx_s;
          k_d            = '0;
          frame_d        = grant_frame_s[FW-1:4];
          eng_in_valid_d = 1'b1;
          eng_in_num_d   = grant_frame_s[3:0];
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        // Digit k is on the engine bus now; frame_q[3:0] already holds digit k+1.
        if (k_q == CNT_W'(DIGITS - 1)) begin
          state_d = WAIT;
          wait_d  = '0;
        end else begin
          k_d            = k_q + CNT_W'(1);
          eng_in_valid_d = 1'b1;
          eng_in_num_d   = frame_q[3:0];
          frame_d        = frame_q >> 3'd4;
        end
      end
      WAIT: begin
        if (bus.eng_out_valid) begin
          result_d         = bus.eng_out;
          err_d            = 1'b0;
          done_d[rr_ptr_q] = 1'b1;
          state_d          = RESP;
        end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
          result_d         = 4'h0;
          err_d            = 1'b1;
          done_d[rr_ptr_q] = 1'b1;
          state_d          = RESP;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= PTR_W'(N_REQ - 1);
      k_q            <= '0;
      wait_q         <= '0;
      frame_q        <= '0;
      eng_in_valid_q <= 1'b0;
      eng_in_num_q   <= 4'h0;
      done_q         <= '0;
      result_q       <= 4'h0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      k_q            <= k_d;
      wait_q         <= wait_d;
      frame_q        <= frame_d;
      eng_in_valid_q <= eng_in_valid_d;
      eng_in_num_q   <= eng_in_num_d;
      done_q         <= done_d;
      result_q       <= result_d;
      err_q          <= err_d;
    end
  end

  assign bus.ack          = ack_s;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.err          = err_q;
  assign bus.eng_in_valid = eng_in_valid_q;
  assign bus.eng_in_num   = eng_in_num_q;
endmodule

// File: tb/tb_checkdigit_sched.sv
// Directed bench for checkdigit_sched with a Luhn-style engine model
// (digit 0 doubled, check digit 0 reported as 4'hF).
module tb_checkdigit_sched;
  localparam int N  = 4;
  localparam int D  = 15;
  localparam int FW = D * 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  checkdigit_sched_if #(.N_REQ(N), .DIGITS(D)) bus ();
  checkdigit_sched #(.N_REQ(N), .DIGITS(D), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Engine model: counts a gap-free burst of D digits, answers one cycle later.
  logic       eng_silent = 1'b0;
  logic       spur       = 1'b0;
  logic       m_vld      = 1'b0;
  logic [3:0] m_res      = 4'h0;
  int         m_cnt      = 0;
  int         m_sum      = 0;

  function automatic int luhn_term(input logic [3:0] d, input int pos);
    int t;
    t = int'(d);
    if (pos % 2 == 0) begin
      t = 2 * t;
      if (t > 9) t = t - 9;
    end
    return t;
  endfunction

  function automatic logic [3:0] luhn_code(input int s);
    int c;
    c = (10 - (s % 10)) % 10;
    return (c == 0) ? 4'hF : 4'(c);
  endfunction

  always @(posedge clk) begin
    m_vld <= 1'b0;
    if (bus.eng_in_valid) begin
      if (m_cnt == D - 1) begin
        m_vld <= !eng_silent;
        m_res <= luhn_code(m_sum + luhn_term(bus.eng_in_num, m_cnt));
        m_cnt <= 0;
        m_sum <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
        m_sum <= m_sum + luhn_term(bus.eng_in_num, m_cnt);
      end
    end else begin
      m_cnt <= 0;
      m_sum <= 0;
    end
  end

  assign bus.eng_out_valid = m_vld | spur;
  assign bus.eng_out       = spur ? 4'h3 : m_res;

  task automatic do_reset;
    bus.req    = '0;
    bus.frame  = '0;
    spur       = 1'b0;
    eng_silent = 1'b0;
    rst_n      = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget, output int cyc, output logic [3:0] d);
    bit found;
    found = 1'b0;
    cyc   = -1;
    d     = 4'h0;
    for (int c = start + 1; c <= start + budget; c++) begin
      if (!found) begin
        @(negedge clk);
        if (bus.done !== 4'h0) begin
          found = 1'b1;
          cyc   = c;
          d     = bus.done;
        end
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    tests_run++;
    if (bus.ack !== 4'h0 || bus.done !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_ack_done: ack=%b done=%b expected 0000/0000", bus.ack, bus.done);
    end
    tests_run++;
    if (bus.result !== 4'h0 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_result: result=%h err=%b expected 0/0", bus.result, bus.err);
    end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.eng_in_valid !== 1'b0 || bus.eng_in_num !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_engine: busy=%b in_valid=%b in_num=%h expected 0/0/0",
               bus.busy, bus.eng_in_valid, bus.eng_in_num);
    end
  endtask

  task automatic test_zero_frame;
    bit burst_ok;
    bus.frame = '0;
    bus.req   = 4'b0010;
    #1;
    tests_run++;
    if (bus.ack !== 4'b0010 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_ack: ack=%b busy=%b expected 0010/0", bus.ack, bus.busy);
    end
    burst_ok = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 4'b0000;
      if (bus.eng_in_valid !== 1'b1 || bus.eng_in_num !== 4'h0 || bus.busy !== 1'b1) burst_ok = 1'b0;
    end
    tests_run++;
    if (!burst_ok) begin
      tests_failed++;
      $display("FAIL zero_burst: got a gap or nonzero digit in cycles 1-15, expected valid=1 num=0");
    end
    @(negedge clk);
    tests_run++;
    if (bus.eng_in_valid !== 1'b0 || bus.done !== 4'h0) begin
      tests_failed++;
      $display("FAIL zero_wait: in_valid=%b done=%b expected 0/0000", bus.eng_in_valid, bus.done);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 4'b0010 || bus.result !== 4'hF || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_done: done=%b result=%h err=%b busy=%b expected 0010/f/0/1",
               bus.done, bus.result, bus.err, bus.busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 4'h0 || bus.busy !== 1'b0 || bus.result !== 4'hF) begin
      tests_failed++;
      $display("FAIL zero_after: done=%b busy=%b result=%h expected 0000/0/f", bus.done, bus.busy, bus.result);
    end
  endtask

  task automatic test_single_digit;
    int         cyc;
    logic [3:0] d;
    bus.frame[0 +: FW] = 60'h1;
    bus.req = 4'b0001;
    #1;
    tests_run++;
    if (bus.ack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL digit_ack: ack=%b expected 0001", bus.ack);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    wait_done(1, 40, cyc, d);
    tests_run++;
    if (cyc != 17 || d !== 4'b0001 || bus.result !== 4'h8 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL digit_done: cycle=%0d done=%b result=%h err=%b expected 17/0001/8/0",
               cyc, d, bus.result, bus.err);
    end
  endtask

  task automatic test_round_robin;
    int         ack_cyc [5];
    int         ack_idx [5];
    int         n_ack, n_burst, bad_len, min_gap, run_len, fall_c, n_done, bad_res, cyc;
    logic       prev_v;
    logic [3:0] d;
    do_reset;
    bus.req = 4'b1111;
    n_ack = 0; n_burst = 0; bad_len = 0; min_gap = 1000; run_len = 0;
    fall_c = -1; n_done = 0; bad_res = 0; prev_v = 1'b0;
    for (int c = 0; c <= 72; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.ack !== 4'h0 && n_ack < 5) begin
        ack_cyc[n_ack] = c;
        ack_idx[n_ack] = -1;
        for (int i = 0; i < N; i++) if (bus.ack[i]) ack_idx[n_ack] = i;
        n_ack++;
      end
      if (bus.eng_in_valid) begin
        if (!prev_v && fall_c >= 0 && (c - fall_c) < min_gap) min_gap = c - fall_c;
        run_len++;
      end else begin
        if (prev_v) begin
          n_burst++;
          if (run_len != D) bad_len++;
          fall_c = c;
        end
        run_len = 0;
      end
      prev_v = bus.eng_in_valid;
      if (bus.done !== 4'h0) begin
        n_done++;
        if (bus.result !== 4'hF || bus.err !== 1'b0) bad_res++;
      end
    end
    tests_run++;
    if (n_ack != 5 || ack_idx[0] != 0 || ack_idx[1] != 1 || ack_idx[2] != 2 || ack_idx[3] != 3 || ack_idx[4] != 0) begin
      tests_failed++;
      $display("FAIL rr_order: %0d acks, order %0d %0d %0d %0d %0d expected 5 acks 0 1 2 3 0",
               n_ack, ack_idx[0], ack_idx[1], ack_idx[2], ack_idx[3], ack_idx[4]);
    end
    tests_run++;
    if (ack_cyc[1] != 18 || ack_cyc[2] != 36 || ack_cyc[3] != 54 || ack_cyc[4] != 72) begin
      tests_failed++;
      $display("FAIL rr_spacing: ack cycles %0d %0d %0d %0d expected 18 36 54 72",
               ack_cyc[1], ack_cyc[2], ack_cyc[3], ack_cyc[4]);
    end
    tests_run++;
    if (n_burst != 4 || bad_len != 0 || min_gap < 2) begin
      tests_failed++;
      $display("FAIL rr_bursts: bursts=%0d bad_len=%0d min_gap=%0d expected 4/0/>=2", n_burst, bad_len, min_gap);
    end
    tests_run++;
    if (n_done != 4 || bad_res != 0) begin
      tests_failed++;
      $display("FAIL rr_dones: dones=%0d bad_results=%0d expected 4/0", n_done, bad_res);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    wait_done(73, 40, cyc, d);
    tests_run++;
    if (cyc != 89 || d !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rr_last_done: cycle=%0d done=%b expected 89/0001", cyc, d);
    end
  endtask

  task automatic test_timeout;
    int         cyc;
    logic [3:0] d;
    @(negedge clk);
    eng_silent = 1'b1;
    bus.frame  = '0;
    bus.req    = 4'b0100;
    #1;
    tests_run++;
    if (bus.ack !== 4'b0100) begin
      tests_failed++;
      $display("FAIL timeout_ack: ack=%b expected 0100", bus.ack);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    wait_done(1, 40, cyc, d);
    tests_run++;
    if (cyc != 20 || d !== 4'b0100 || bus.err !== 1'b1 || bus.result !== 4'h0) begin
      tests_failed++;
      $display("FAIL timeout_done: cycle=%0d done=%b err=%b result=%h expected 20/0100/1/0",
               cyc, d, bus.err, bus.result);
    end
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 4'h0) begin
      tests_failed++;
      $display("FAIL timeout_idle: busy=%b done=%b expected 0/0000", bus.busy, bus.done);
    end
    eng_silent = 1'b0;
  endtask

  task automatic test_reset_mid;
    int         cyc;
    bit         stray_done;
    logic [3:0] d;
    bus.frame = '0;
    bus.req   = 4'b0010;
    #1;
    tests_run++;
    if (bus.ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL midrst_ack: ack=%b expected 0010", bus.ack);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 4'b0000;
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.eng_in_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 4'h0) begin
      tests_failed++;
      $display("FAIL midrst_abort: in_valid=%b busy=%b done=%b expected 0/0/0000",
               bus.eng_in_valid, bus.busy, bus.done);
    end
    rst_n = 1'b0;
    stray_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 4'h0 || bus.busy !== 1'b0) stray_done = 1'b1;
    end
    tests_run++;
    if (stray_done) begin
      tests_failed++;
      $display("FAIL midrst_quiet: done or busy seen after abort, expected none");
    end
    bus.req = 4'b0110;
    #1;
    tests_run++;
    if (bus.ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL midrst_ptr: ack=%b expected 0010", bus.ack);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    wait_done(1, 40, cyc, d);
    @(negedge clk);
    bus.req = 4'b0100;
    #1;
    tests_run++;
    if (bus.ack !== 4'b0100) begin
      tests_failed++;
      $display("FAIL midrst_req2: ack=%b expected 0100", bus.ack);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    wait_done(1, 40, cyc, d);
    tests_run++;
    if (cyc != 17 || d !== 4'b0100 || bus.result !== 4'hF) begin
      tests_failed++;
      $display("FAIL midrst_req2_done: cycle=%0d done=%b result=%h expected 17/0100/f", cyc, d, bus.result);
    end
  endtask

  task automatic test_frame_latch;
    int         cyc;
    bit         early;
    logic [3:0] d;
    @(negedge clk);
    bus.frame[3*FW +: FW] = 60'h50;
    bus.req = 4'b1000;
    #1;
    tests_run++;
    if (bus.ack !== 4'b1000) begin
      tests_failed++;
      $display("FAIL latch_ack: ack=%b expected 1000", bus.ack);
    end
    early = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req = 4'b0000;
        bus.frame[3*FW +: FW] = 60'h1;
      end
      if (c == 5) spur = 1'b1;
      if (c == 6) spur = 1'b0;
      if (bus.done !== 4'h0) early = 1'b1;
    end
    wait_done(6, 40, cyc, d);
    tests_run++;
    if (early || cyc != 17 || d !== 4'b1000) begin
      tests_failed++;
      $display("FAIL latch_timing: early=%0d cycle=%0d done=%b expected 0/17/1000", early, cyc, d);
    end
    tests_run++;
    if (bus.result !== 4'h5 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL latch_result: result=%h err=%b expected 5/0", bus.result, bus.err);
    end
  endtask

  initial begin
    bus.req   = '0;
    bus.frame = '0;
    test_reset;
    test_zero_frame;
    test_single_digit;
    test_round_robin;
    test_timeout;
    test_reset_mid;
    test_frame_latch;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
